// File: rtl/cmp_pkg.sv
// Shared compare-mode encoding and flag bit positions for the execute stage,
// the branch comparator and the pipelined set-on-less-than unit.
package cmp_pkg;
  localparam logic [2:0] CMP_SLT  = 3'd0;
  localparam logic [2:0] CMP_SLTU = 3'd1;
  localparam logic [2:0] CMP_SEQ  = 3'd2;
  localparam logic [2:0] CMP_SNE  = 3'd3;
  localparam logic [2:0] CMP_SLE  = 3'd4;
  localparam logic [2:0] CMP_SLEU = 3'd5;
  localparam logic [2:0] CMP_MIN  = 3'd6;
  localparam logic [2:0] CMP_MAXU = 3'd7;

  localparam int FLG_NEG    = 0;
  localparam int FLG_OVF    = 1;
  localparam int FLG_BORROW = 2;
  localparam int FLG_ZERO   = 3;
endpackage

// File: rtl/cmp_flags.sv
// Combinational A-B flag generator: one WIDTH+1-bit subtraction yields
// neg, signed overflow, unsigned borrow and zero.
module cmp_flags
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       flags
);
  logic [WIDTH:0] diff;

  // Carry out of A + ~B + 1 is the inverse of the unsigned borrow.
  assign diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    flags             = '0;
    flags[FLG_NEG]    = diff[WIDTH-1];
    flags[FLG_BORROW] = ~diff[WIDTH];
    flags[FLG_OVF]    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
    flags[FLG_ZERO]   = (diff[WIDTH-1:0] == '0);
  end
endmodule

// File: rtl/slt_pipe_unit.sv
// Two-stage set-on-less-than / min / max functional unit with valid/ready
// handshake, tag passthrough and synchronous flush.
module slt_pipe_unit
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_mode,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAGW-1:0]  out_tag,
  output logic [3:0]       out_flags
);
  if (WIDTH < 8 || WIDTH > 64) begin : g_bad_width
    $error("slt_pipe_unit: WIDTH must be in 8..64");
  end

  // Handshake: a transfer happens on an edge where valid && ready at a port.
  // A stage advances when it is empty or its consumer takes its contents;
  // in_ready is combinational from out_ready and never looks at in_valid.
  logic adv1, adv2;
  logic s1_valid, s2_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  logic [2:0]       s1_mode;
  logic [TAGW-1:0]  s1_tag;
  logic [3:0]       s1_flags;
  logic [3:0]       flags_c;
  logic [WIDTH-1:0] sel_result;
  logic             slt, ult, zero, set_bit;

  assign adv2      = ~s2_valid | out_ready;
  assign adv1      = ~s1_valid | adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_valid;

  cmp_flags #(.WIDTH(WIDTH)) u_flags (
    .a     (in_a),
    .b     (in_b),
    .flags (flags_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_mode  <= '0;
      s1_tag   <= '0;
      s1_flags <= '0;
    end else begin
      if (flush)     s1_valid <= 1'b0;
      else if (adv1) s1_valid <= in_valid;
      if (adv1 && in_valid) begin
        s1_a     <= in_a;
        s1_b     <= in_b;
        s1_mode  <= in_mode;
        s1_tag   <= in_tag;
        s1_flags <= flags_c;
      end
    end
  end

  always_comb begin
    slt        = s1_flags[FLG_NEG] ^ s1_flags[FLG_OVF];
    ult        = s1_flags[FLG_BORROW];
    zero       = s1_flags[FLG_ZERO];
    set_bit    = 1'b0;
    sel_result = '0;
    case (s1_mode)
      CMP_SLT:  set_bit = slt;
      CMP_SLTU: set_bit = ult;
      CMP_SEQ:  set_bit = zero;
      CMP_SNE:  set_bit = ~zero;
      CMP_SLE:  set_bit = slt | zero;
      CMP_SLEU: set_bit = ult | zero;
      default:  set_bit = 1'b0;
    endcase
    if (s1_mode == CMP_MIN)       sel_result = slt ? s1_a : s1_b;
    else if (s1_mode == CMP_MAXU) sel_result = ult ? s1_b : s1_a;
    else                          sel_result = {{(WIDTH-1){1'b0}}, set_bit};
  end

  // Output registers only load on advance, so they hold while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_flags  <= '0;
    end else begin
      if (flush)     s2_valid <= 1'b0;
      else if (adv2) s2_valid <= s1_valid;
      if (adv2 && s1_valid) begin
        out_result <= sel_result;
        out_tag    <= s1_tag;
        out_flags  <= s1_flags;
      end
    end
  end
endmodule

// File: doc/slt_pipe_unit.md
Name: slt_pipe_unit

Overview:
- Parametrised, pipelined successor to the single-cycle set-on-less-than logic of the integer execute stage.
- Takes two WIDTH-bit operands plus a compare mode and computes the flags (NEG, OVF, borrow, zero) from one subtraction.
- Produces a zero-extended set result, or a min/max operand value.
- Two registered stages with valid/ready handshake, a tag passthrough and a flush, so it can sit beside the ALU as a decoupled functional unit.

Parameters:
- WIDTH, 32, operand and result width; legal range 8 to 64.
- TAGW, 5, width of the opaque tag carried with each operation (destination register index).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit accepts this cycle.
- in_mode  in  3  0 SLT, 1 SLTU, 2 SEQ, 3 SNE, 4 SLE, 5 SLEU, 6 MIN (signed), 7 MAXU (unsigned).
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_tag  in  TAGW  tag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts.
- out_result  out  WIDTH  result.
- out_tag  out  TAGW  tag of result.
- out_flags  out  4  {zero, borrow, ovf, neg} of A-B, for debug/branch reuse.

Behaviour:
- Reset (reset_n low, asynchronous): both stage valid bits = 0. out_valid = 0, out_result = 0, out_tag = 0, out_flags = 0. in_ready = 1 after release.
- Stage 1 (S1) registers:
  - diff = {1'b0,A} + {1'b0,~B} + 1, computed as WIDTH+1 bits.
  - neg = diff[WIDTH-1].
  - borrow = ~diff[WIDTH].
  - ovf = (A[msb] != B[msb]) && (diff[WIDTH-1] != A[msb]).
  - zero = (diff[WIDTH-1:0] == 0).
  - Also registers A, B, mode and tag.
- Stage 2 (S2, output register) selects by mode:
  - slt = neg ^ ovf; ult = borrow.
  - SLT → {0, slt}. SLTU → {0, ult}.
  - SEQ → {0, zero}. SNE → {0, ~zero}.
  - SLE → {0, slt|zero}. SLEU → {0, ult|zero}.
  - MIN → slt ? A : B. MAXU → ult ? B : A.
  - Set results are zero-extended to WIDTH.
- Latency: exactly 2 cycles from accept to out_valid when unstalled. Throughput: 1 operation per cycle.
- Handshake:
  - Transfer on valid&&ready at both ports.
  - adv2 = ~s2_valid | out_ready.
  - adv1 = ~s1_valid | adv2.
  - in_ready = adv1; it is combinational from out_ready (no skid buffer).
  - in_ready does not depend on in_valid.
  - out_* stay stable while out_valid && ~out_ready.
- Bubbles: an empty S2 is filled from S1 even when out_ready = 0.
- flush: at the next edge s1_valid = s2_valid = 0. An input presented in the flush cycle is discarded, even if in_ready was 1. out_valid drops the cycle after flush. Datapath registers need not clear.
- Simultaneous accept and output in the same cycle: both stages shift; no operation is lost or duplicated.
- Reset mid-operation: all in-flight operations are dropped. No output is produced for operations accepted before reset.
- Illegal WIDTH is rejected at elaboration.

Decomposition:
- Shared package cmp_pkg:
  - Mode encoding constants CMP_SLT..CMP_MAXU (3 bits).
  - Flag index constants FLG_NEG=0, FLG_OVF=1, FLG_BORROW=2, FLG_ZERO=3.
- The execute-stage decoder imports cmp_pkg for the same encoding.
- One natural sub-module, cmp_flags: purely combinational, WIDTH-parametrised subtraction/flag generator used by S1. It is reusable by the branch comparator.
- Stage control and mode select stay in slt_pipe_unit.

Test Plan:
- SLT A=0x80000000, B=0x00000001 (ovf path); next cycle SLTU with the same operands → results 0x00000001 then 0x00000000, out_valid on cycles 2 and 3 after the first accept, out_flags for first = {0,0,1,0}.
- SEQ/SNE/SLE/SLEU with A=B=0xFFFFFFFF → 1,0,1,1; MIN A=0xFFFFFFFE(-2),B=5 → 0xFFFFFFFE; MAXU same operands → 0xFFFFFFFE.
- Back-to-back stream of 8 ops with out_ready held 0 for cycles 3–6 → in_ready low once both stages full, results emerge in order with matching tags 0..7, no drops or duplicates, outputs stable during stall.
- Assert flush while two ops are in flight and in_valid=1 with tag 9 → out_valid low next cycle, tag 9 never appears, next op accepted afterwards returns after 2 cycles.
- Pull reset_n low asynchronously mid-cycle with S1 and S2 full → out_valid, out_result, out_tag, out_flags go to 0 immediately; after release, first accepted op completes normally.
- WIDTH=8 instance: SLT A=0x7F, B=0x80 → 0x00; SLTU same operands → 0x01; MIN → 0x80.
